// File: rtl/mdr_sched_pkg.sv
// Shared types for the MDR scheduler.
//   MDR_DW        : default operand/result width of the shared MDR unit
//   data_t        : one MDR data word
//   op_t          : requester/MDR operation code
//   sched_state_t : scheduler FSM states
package mdr_sched_pkg;

  localparam int MDR_DW = 16;

  typedef logic [MDR_DW-1:0] data_t;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_INV  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_X,
    LOAD_X,
    WAIT_Y,
    LOAD_Y,
    BUSY,
    DONE
  } sched_state_t;

endpackage

// File: rtl/mdr_sched_if.sv
// Handshake bus between the scheduler and the single MDR instance.
//   start     : one-cycle start pulse          (sched -> MDR)
//   op        : operation, held START..DONE    (sched -> MDR)
//   data      : operand bus, 0 outside loads   (sched -> MDR)
//   load      : operand-load strobe            (sched -> MDR)
//   load_x/_y : MDR ready for X / Y            (MDR -> sched)
//   ready     : result valid                   (MDR -> sched)
//   error     : error, sampled with ready      (MDR -> sched)
//   result    : result word                    (MDR -> sched)
//   remainder : remainder word                 (MDR -> sched)
interface mdr_sched_if #(parameter int DW = 16);
  logic          start;
  logic [1:0]    op;
  logic [DW-1:0] data;
  logic          load;
  logic          load_x;
  logic          load_y;
  logic          ready;
  logic          error;
  logic [DW-1:0] result;
  logic [DW-1:0] remainder;

  modport master (
    output start, op, data, load,
    input  load_x, load_y, ready, error, result, remainder
  );

  modport slave (
    input  start, op, data, load,
    output load_x, load_y, ready, error, result, remainder
  );
endinterface

// File: rtl/mdr_sched_rr_arbiter.sv
// Combinational round-robin winner search.
//   i_req : request levels
//   i_ptr : index of the last served requester
//   o_vld : some request is pending
//   o_idx : first requester with req high searching from i_ptr+1, wrapping
module mdr_sched_rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic             o_vld,
  output logic [IW-1:0]    o_idx
);

  logic [IW-1:0] w_j;

  // Walk from the farthest candidate down to ptr+1 so the nearest one
  // is the last assignment and therefore wins.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    w_j   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N_REQ);
      if (i_req[w_j]) begin
        o_vld = 1'b1;
        o_idx = w_j;
      end
    end
  end

endmodule

// File: rtl/mdr_sched.sv
// Round-robin scheduler sharing one multiply/divide/root unit among N_REQ
// requesters. Grants one requester at a time and runs the MDR
// start/load_x/load_y/ready handshake for it.
//   clk, rst          : clock, synchronous active-high reset
//   i_req             : per-requester request level
//   i_req_op          : per-requester op (00 mul, 01 div, 10 sqrt, 11 invalid)
//   i_req_x / i_req_y : per-requester operands (Y unused for sqrt)
//   o_gnt             : one-hot grant, held for the whole operation
//   o_done            : one-cycle completion pulse to the granted requester
//   o_rsp_*           : shared response, valid while any o_done bit is high
//   mdr               : master side of the MDR handshake bus
module mdr_sched
  import mdr_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = MDR_DW,
  parameter int TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ-1:0][1:0]      i_req_op,
  input  logic [N_REQ-1:0][DW-1:0]   i_req_x,
  input  logic [N_REQ-1:0][DW-1:0]   i_req_y,
  output logic [N_REQ-1:0]           o_gnt,
  output logic [N_REQ-1:0]           o_done,
  output logic [DW-1:0]              o_rsp_result,
  output logic [DW-1:0]              o_rsp_remainder,
  output logic                       o_rsp_error,
  output logic                       o_rsp_timeout,
  mdr_sched_if.master                mdr
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  sched_state_t     r_state;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_ptr;
  op_t              r_op;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic [DW-1:0]    r_result;
  logic [DW-1:0]    r_rem;
  logic [DW-1:0]    r_data;
  logic             r_err;
  logic             r_tmo;
  logic             r_start;
  logic             r_load;
  logic [1:0]       r_mdr_op;

  logic             w_win_vld;
  logic [IW-1:0]    w_win_idx;
  logic [N_REQ-1:0] w_win_oh;
  op_t              w_win_op;
  logic             w_waiting;
  logic             w_hs;
  logic             w_abort;

  mdr_sched_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_vld (w_win_vld),
    .o_idx (w_win_idx)
  );

  assign w_win_oh  = N_REQ'(1) << w_win_idx;
  assign w_win_op  = op_t'(i_req_op[w_win_idx]);
  assign w_waiting = (r_state == WAIT_X) || (r_state == WAIT_Y) || (r_state == BUSY);
  assign w_hs      = ((r_state == WAIT_X) && mdr.load_x) ||
                     ((r_state == WAIT_Y) && mdr.load_y) ||
                     ((r_state == BUSY)   && mdr.ready);
  // A handshake arriving on the terminal count still wins over the abort.
  assign w_abort   = w_waiting && !w_hs && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_ptr    <= IW'(N_REQ - 1);
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_rem    <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
      r_tmo    <= 1'b0;
      r_start  <= 1'b0;
      r_load   <= 1'b0;
      r_mdr_op <= '0;
    end else begin
      // Pulse outputs default low; each state re-asserts what it needs.
      r_start <= 1'b0;
      r_load  <= 1'b0;
      r_data  <= '0;
      r_done  <= '0;
      if (w_abort) begin
        r_state  <= DONE;
        r_done   <= r_gnt;
        r_tmo    <= 1'b1;
        r_err    <= 1'b1;
        r_result <= '0;
        r_rem    <= '0;
      end else begin
        case (r_state)
          IDLE: if (w_win_vld) begin
            r_idx <= w_win_idx;
            r_gnt <= w_win_oh;
            r_op  <= w_win_op;
            r_cnt <= '0;
            if (w_win_op == OP_INV) begin
              // Invalid op completes without touching the MDR.
              r_state  <= DONE;
              r_done   <= w_win_oh;
              r_err    <= 1'b1;
              r_tmo    <= 1'b0;
              r_result <= '0;
              r_rem    <= '0;
            end else begin
              r_state  <= START;
              r_start  <= 1'b1;
              r_mdr_op <= w_win_op;
            end
          end
          START: r_state <= WAIT_X;
          WAIT_X: begin
            r_cnt <= r_cnt + 1'b1;
            if (mdr.load_x) begin
              r_state <= LOAD_X;
              r_load  <= 1'b1;
              r_data  <= i_req_x[r_idx];
            end
          end
          LOAD_X: r_state <= (r_op == OP_SQRT) ? BUSY : WAIT_Y;
          WAIT_Y: begin
            r_cnt <= r_cnt + 1'b1;
            if (mdr.load_y) begin
              r_state <= LOAD_Y;
              r_load  <= 1'b1;
              r_data  <= i_req_y[r_idx];
            end
          end
          LOAD_Y: r_state <= BUSY;
          BUSY: begin
            r_cnt <= r_cnt + 1'b1;
            if (mdr.ready) begin
              r_state  <= DONE;
              r_done   <= r_gnt;
              r_result <= mdr.result;
              r_rem    <= mdr.remainder;
              r_err    <= mdr.error;
              r_tmo    <= 1'b0;
            end
          end
          DONE: begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_ptr    <= r_idx;
            r_mdr_op <= '0;
            r_err    <= 1'b0;
            r_tmo    <= 1'b0;
            r_result <= '0;
            r_rem    <= '0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_gnt           = r_gnt;
  assign o_done          = r_done;
  assign o_rsp_result    = r_result;
  assign o_rsp_remainder = r_rem;
  assign o_rsp_error     = r_err;
  assign o_rsp_timeout   = r_tmo;
  assign mdr.start       = r_start;
  assign mdr.op          = r_mdr_op;
  assign mdr.data        = r_data;
  assign mdr.load        = r_load;

endmodule

// File: tb/tb_mdr_sched.sv
module tb_mdr_sched;
  import mdr_sched_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]         req;
  logic [N-1:0][1:0]    req_op;
  logic [N-1:0][DW-1:0] req_x, req_y;
  logic [N-1:0]         gnt, done;
  logic [DW-1:0]        rsp_result, rsp_rem;
  logic                 rsp_err, rsp_tmo;

  mdr_sched_if #(.DW(DW)) mif ();

  mdr_sched #(.N_REQ(N), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_req_op(req_op), .i_req_x(req_x), .i_req_y(req_y),
    .o_gnt(gnt), .o_done(done), .o_rsp_result(rsp_result), .o_rsp_remainder(rsp_rem),
    .o_rsp_error(rsp_err), .o_rsp_timeout(rsp_tmo), .mdr(mif)
  );

  int total = 0;
  int bad   = 0;

  // Arithmetic reference: {error, result, remainder}.
  // mul: result = low word, remainder = high word of the product.
  function automatic logic [2*DW:0] ref_calc(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [2*DW-1:0] p;
    int r;
    case (op)
      2'd0: begin p = (2*DW)'(x) * (2*DW)'(y); return {1'b0, p[DW-1:0], p[2*DW-1:DW]}; end
      2'd1: if (y == '0) return {1'b1, {(2*DW){1'b0}}}; else return {1'b0, x / y, x % y};
      2'd2: begin
        r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return {1'b0, DW'(r), DW'(int'(x) - r * r)};
      end
      default: return {1'b1, {(2*DW){1'b0}}};
    endcase
  endfunction

  // Behavioural MDR: load_x after start, load_y after X (not for sqrt),
  // ready m_delay cycles after the last operand (0 = first BUSY cycle).
  typedef enum {M_IDLE, M_WX, M_WY, M_CALC} mst_t;
  mst_t       m_st;
  int         m_delay = 0;
  bit         m_hang = 1'b0;
  int         m_cnt;
  logic [1:0] m_op;
  logic [DW-1:0] m_x;

  always @(posedge clk) begin
    if (rst) begin
      m_st <= M_IDLE; m_cnt <= 0; m_op <= '0; m_x <= '0;
      mif.load_x <= 1'b0; mif.load_y <= 1'b0; mif.ready <= 1'b0;
      mif.error <= 1'b0; mif.result <= '0; mif.remainder <= '0;
    end else begin
      mif.ready <= 1'b0;
      case (m_st)
        M_IDLE: if (mif.start && !m_hang) begin
          m_op <= mif.op; mif.load_x <= 1'b1; m_st <= M_WX;
        end
        M_WX: if (mif.load) begin
          m_x <= mif.data; mif.load_x <= 1'b0;
          if (m_op == 2'd2) begin
            {mif.error, mif.result, mif.remainder} <= ref_calc(m_op, mif.data, '0);
            if (m_delay == 0) begin mif.ready <= 1'b1; m_st <= M_IDLE; end
            else begin m_cnt <= m_delay - 1; m_st <= M_CALC; end
          end else begin
            mif.load_y <= 1'b1; m_st <= M_WY;
          end
        end
        M_WY: if (mif.load) begin
          mif.load_y <= 1'b0;
          {mif.error, mif.result, mif.remainder} <= ref_calc(m_op, m_x, mif.data);
          if (m_delay == 0) begin mif.ready <= 1'b1; m_st <= M_IDLE; end
          else begin m_cnt <= m_delay - 1; m_st <= M_CALC; end
        end
        M_CALC: if (m_cnt == 0) begin mif.ready <= 1'b1; m_st <= M_IDLE; end
                else m_cnt <= m_cnt - 1;
        default: m_st <= M_IDLE;
      endcase
    end
  end

  // Running event counters, sampled on the falling edge.
  int n_start = 0, n_load = 0, n_multi = 0, n_done = 0, n_databad = 0;
  always @(negedge clk) begin
    n_start <= n_start + int'(mif.start);
    n_load  <= n_load + int'(mif.load);
    n_done  <= n_done + int'(|done);
    if ($countones(gnt) > 1) n_multi <= n_multi + 1;
    if (!mif.load && mif.data != '0) n_databad <= n_databad + 1;
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    req_op[i] = op; req_x[i] = x; req_y[i] = y; req[i] = 1'b1;
  endtask

  task automatic wait_done(input int maxc, output int idx, output int cyc, output logic [N-1:0] g,
                           output logic [DW-1:0] res, output logic [DW-1:0] rem,
                           output logic err, output logic tmo);
    idx = -1; cyc = -1; g = '0; res = '0; rem = '0; err = 1'b0; tmo = 1'b0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (|done) begin
        for (int i = 0; i < N; i++) if (done[i]) idx = i;
        cyc = c; g = gnt; res = rsp_result; rem = rsp_rem; err = rsp_err; tmo = rsp_tmo;
        break;
      end
    end
  endtask

  int idx, cyc, s0, l0, d0;
  logic [N-1:0] g;
  logic [DW-1:0] res, rem;
  logic err, tmo;

  task automatic test_reset();
    rst = 1'b1; req = '0; req_op = '0; req_x = '0; req_y = '0;
    repeat (3) @(negedge clk);
    total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    total++; if (done !== '0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if ({rsp_result, rsp_rem, rsp_err, rsp_tmo} !== '0) begin bad++; $display("FAIL reset_rsp: got %h/%h/%b/%b want 0", rsp_result, rsp_rem, rsp_err, rsp_tmo); end
    total++; if ({mif.start, mif.load, mif.op, mif.data} !== '0) begin bad++; $display("FAIL reset_mdr: got start=%b load=%b op=%0d data=%h want 0", mif.start, mif.load, mif.op, mif.data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    m_delay = 0; s0 = n_start; l0 = n_load; d0 = n_done;
    @(negedge clk); set_req(0, 2'd0, 16'd7, 16'd6);
    wait_done(50, idx, cyc, g, res, rem, err, tmo); req[0] = 1'b0;
    total++; if (idx !== 0) begin bad++; $display("FAIL mul_idx: got %0d want 0", idx); end
    total++; if (cyc !== 8 - 1) begin bad++; $display("FAIL mul_latency: got %0d want 7", cyc); end
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL mul_gnt: got %b want 0001", g); end
    total++; if ({err, tmo, res, rem} !== {2'b00, 16'd42, 16'd0}) begin bad++; $display("FAIL mul_rsp: got err=%b tmo=%b res=%0d rem=%0d want 0 0 42 0", err, tmo, res, rem); end
    repeat (3) @(negedge clk);
    total++; if (n_start - s0 !== 1) begin bad++; $display("FAIL mul_starts: got %0d want 1", n_start - s0); end
    total++; if (n_load - l0 !== 2) begin bad++; $display("FAIL mul_loads: got %0d want 2", n_load - l0); end
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL mul_done_width: got %0d want 1", n_done - d0); end
    total++; if (gnt !== '0) begin bad++; $display("FAIL mul_gnt_drop: got %b want 0", gnt); end
  endtask

  task automatic test_div();
    m_delay = 0;
    @(negedge clk); set_req(1, 2'd1, 16'd17, 16'd5);
    wait_done(50, idx, cyc, g, res, rem, err, tmo); req[1] = 1'b0;
    total++; if (idx !== 1 || cyc !== 7) begin bad++; $display("FAIL div_idx_lat: got %0d/%0d want 1/7", idx, cyc); end
    total++; if ({err, res, rem} !== {1'b0, 16'd3, 16'd2}) begin bad++; $display("FAIL div_rsp: got err=%b res=%0d rem=%0d want 0 3 2", err, res, rem); end
    repeat (2) @(negedge clk);
    m_delay = 2; d0 = n_done;
    @(negedge clk); set_req(1, 2'd1, 16'd9, 16'd0);
    wait_done(50, idx, cyc, g, res, rem, err, tmo); req[1] = 1'b0;
    total++; if (idx !== 1 || cyc !== 9) begin bad++; $display("FAIL div0_idx_lat: got %0d/%0d want 1/9", idx, cyc); end
    total++; if (err !== 1'b1 || tmo !== 1'b0) begin bad++; $display("FAIL div0_err: got err=%b tmo=%b want 1 0", err, tmo); end
    repeat (3) @(negedge clk);
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL div0_done_count: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_sqrt();
    m_delay = 0; l0 = n_load;
    @(negedge clk); set_req(2, 2'd2, 16'd49, 16'd123);
    wait_done(50, idx, cyc, g, res, rem, err, tmo); req[2] = 1'b0;
    total++; if (idx !== 2 || cyc !== 5) begin bad++; $display("FAIL sqrt_idx_lat: got %0d/%0d want 2/5", idx, cyc); end
    total++; if ({err, res, rem} !== {1'b0, 16'd7, 16'd0}) begin bad++; $display("FAIL sqrt_rsp: got err=%b res=%0d rem=%0d want 0 7 0", err, res, rem); end
    repeat (3) @(negedge clk);
    total++; if (n_load - l0 !== 1) begin bad++; $display("FAIL sqrt_loads: got %0d want 1", n_load - l0); end
  endtask

  task automatic test_invalid();
    s0 = n_start;
    @(negedge clk); set_req(2, 2'd3, 16'd5, 16'd5);
    wait_done(20, idx, cyc, g, res, rem, err, tmo); req[2] = 1'b0;
    total++; if (idx !== 2 || cyc !== 1) begin bad++; $display("FAIL inv_idx_lat: got %0d/%0d want 2/1", idx, cyc); end
    total++; if ({err, tmo, res, rem} !== {2'b10, 32'd0}) begin bad++; $display("FAIL inv_rsp: got err=%b tmo=%b res=%0d rem=%0d want 1 0 0 0", err, tmo, res, rem); end
    repeat (3) @(negedge clk);
    total++; if (n_start - s0 !== 0) begin bad++; $display("FAIL inv_no_start: got %0d want 0", n_start - s0); end
  endtask

  task automatic test_timeout();
    m_hang = 1'b1; s0 = n_start;
    @(negedge clk); set_req(3, 2'd0, 16'd3, 16'd3);
    wait_done(60, idx, cyc, g, res, rem, err, tmo); req[3] = 1'b0;
    // START seen at cycle 1, left at cycle 2, done TIMEOUT cycles later.
    total++; if (idx !== 3 || cyc !== 2 + TMO) begin bad++; $display("FAIL tmo_idx_lat: got %0d/%0d want 3/%0d", idx, cyc, 2 + TMO); end
    total++; if ({tmo, err, res, rem} !== {2'b11, 32'd0}) begin bad++; $display("FAIL tmo_rsp: got tmo=%b err=%b res=%0d rem=%0d want 1 1 0 0", tmo, err, res, rem); end
    total++; if (g !== 4'b1000) begin bad++; $display("FAIL tmo_gnt: got %b want 1000", g); end
    repeat (3) @(negedge clk);
    total++; if (n_start - s0 !== 1) begin bad++; $display("FAIL tmo_starts: got %0d want 1", n_start - s0); end
    m_hang = 1'b0;
  endtask

  // Instant X/Y handshakes leave the counter at 2 on the first BUSY cycle, so
  // ready after TMO-3 extra cycles lands on the terminal count and must win.
  task automatic test_ready_wins();
    m_delay = TMO - 3;
    @(negedge clk); set_req(0, 2'd0, 16'd300, 16'd500);
    wait_done(60, idx, cyc, g, res, rem, err, tmo); req[0] = 1'b0;
    total++; if (idx !== 0 || cyc !== TMO + 4) begin bad++; $display("FAIL edge_ready_lat: got %0d/%0d want 0/%0d", idx, cyc, TMO + 4); end
    total++; if ({tmo, err, res, rem} !== {2'b00, ref_calc(2'd0, 16'd300, 16'd500)}) begin bad++; $display("FAIL edge_ready_rsp: got tmo=%b err=%b res=%0d rem=%0d", tmo, err, res, rem); end
    repeat (4) @(negedge clk);
    m_delay = TMO - 2;
    @(negedge clk); set_req(0, 2'd0, 16'd300, 16'd500);
    wait_done(60, idx, cyc, g, res, rem, err, tmo); req[0] = 1'b0;
    total++; if (idx !== 0 || cyc !== TMO + 4) begin bad++; $display("FAIL edge_tmo_lat: got %0d/%0d want 0/%0d", idx, cyc, TMO + 4); end
    total++; if ({tmo, err, res} !== {2'b11, 16'd0}) begin bad++; $display("FAIL edge_tmo_rsp: got tmo=%b err=%b res=%0d want 1 1 0", tmo, err, res); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    m_delay = 10;
    @(negedge clk); set_req(1, 2'd0, 16'd5, 16'd5);
    repeat (8) @(negedge clk);
    d0 = n_done;
    rst = 1'b1;
    @(negedge clk);
    total++; if ({gnt, done, rsp_result, rsp_rem, rsp_err, rsp_tmo} !== '0) begin bad++; $display("FAIL rstmid_outs: got gnt=%b done=%b res=%0d err=%b", gnt, done, rsp_result, rsp_err); end
    total++; if ({mif.start, mif.load, mif.op, mif.data} !== '0) begin bad++; $display("FAIL rstmid_mdr: got start=%b load=%b op=%0d data=%h want 0", mif.start, mif.load, mif.op, mif.data); end
    req = '0;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (n_done - d0 !== 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", n_done - d0); end
    m_delay = 0;
    set_req(1, 2'd0, 16'd3, 16'd4); set_req(3, 2'd1, 16'd8, 16'd2);
    wait_done(50, idx, cyc, g, res, rem, err, tmo); req[1] = 1'b0;
    total++; if (idx !== 1 || res !== 16'd12) begin bad++; $display("FAIL rstmid_first: got idx=%0d res=%0d want 1 12", idx, res); end
    wait_done(50, idx, cyc, g, res, rem, err, tmo); req[3] = 1'b0;
    total++; if (idx !== 3 || res !== 16'd4) begin bad++; $display("FAIL rstmid_second: got idx=%0d res=%0d want 3 4", idx, res); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int m0;
    do_reset();
    m_delay = 0; m0 = n_multi;
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 2'd0, 16'd2, 16'd3);
    for (int k = 0; k < 5; k++) begin
      wait_done(50, idx, cyc, g, res, rem, err, tmo);
      total++; if (idx !== k % N || res !== 16'd6) begin bad++; $display("FAIL rr_order%0d: got idx=%0d res=%0d want %0d 6", k, idx, res, k % N); end
      total++; if (cyc !== (k == 0 ? 7 : 8)) begin bad++; $display("FAIL rr_gap%0d: got %0d want %0d", k, cyc, k == 0 ? 7 : 8); end
    end
    req = '0;
    repeat (3) @(negedge clk);
    total++; if (n_multi - m0 !== 0) begin bad++; $display("FAIL rr_multihot: got %0d want 0", n_multi - m0); end
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [2*DW:0] e;
    int ptr, exp_i, m0, b0;
    do_reset();
    ptr = N - 1; m0 = n_multi; b0 = n_databad;
    for (int r = 0; r < 12; r++) begin
      pend = N'($urandom_range(1, (1 << N) - 1));
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (pend[i])
          set_req(i, 2'($urandom_range(0, 3)), DW'($urandom),
                  ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom));
      m_delay = $urandom_range(0, 3);
      while (pend != '0) begin
        exp_i = -1;
        for (int k = 1; k <= N; k++)
          if (exp_i < 0 && pend[(ptr + k) % N]) exp_i = (ptr + k) % N;
        e = ref_calc(req_op[exp_i], req_x[exp_i], req_y[exp_i]);
        wait_done(80, idx, cyc, g, res, rem, err, tmo);
        total++; if (idx !== exp_i || g !== N'(1) << exp_i) begin bad++; $display("FAIL rand_grant: got idx=%0d gnt=%b want %0d", idx, g, exp_i); end
        total++; if ({err, res, rem} !== e || tmo !== 1'b0) begin bad++; $display("FAIL rand_rsp: got %b/%h/%h tmo=%b want %b/%h/%h op=%0d", err, res, rem, tmo, e[2*DW], e[2*DW-1:DW], e[DW-1:0], req_op[exp_i]); end
        req[exp_i] = 1'b0; pend[exp_i] = 1'b0; ptr = exp_i;
        m_delay = $urandom_range(0, 3);
      end
      repeat (2) @(negedge clk);
    end
    total++; if (n_multi - m0 !== 0) begin bad++; $display("FAIL rand_multihot: got %0d want 0", n_multi - m0); end
    total++; if (n_databad - b0 !== 0) begin bad++; $display("FAIL rand_data_idle: got %0d want 0", n_databad - b0); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_sqrt();
    test_invalid();
    test_timeout();
    test_ready_wins();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
